// File: rtl/fifo_pkg.sv
// Shared defaults and transaction record for the single-clock FIFO,
// used by the RTL, the interface bundle and the monitor.
package fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  // One clock cycle of FIFO activity as seen at the pins.
  typedef struct packed {
    logic [DEF_FIFO_WIDTH-1:0] data_in;
    logic                      wr_en;
    logic                      rd_en;
    logic [DEF_FIFO_WIDTH-1:0] data_out;
    logic                      wr_ack;
    logic                      overflow;
    logic                      underflow;
    logic                      full;
    logic                      empty;
    logic                      almostfull;
    logic                      almostempty;
  } fifo_txn_t;

  // Pointer width for a power-of-two depth; count needs one more bit.
  function automatic int ptr_bits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one write port and one registered read port.
// Read data resets to zero; the array itself is not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_FIFO_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int AW    = ptr_bits(DEF_FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data holds whenever no read is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo.sv
// Synchronous single-clock FIFO: pointers, occupancy count, status flags
// and registered request pulses around the fifo_mem storage.
module fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty
);

  localparam int PTR_W = ptr_bits(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // A write into a full FIFO and a read from an empty one are simply not
  // accepted; simultaneous requests at the boundaries fall out of this.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign almostfull  = (count == CNT_W'(FIFO_DEPTH - 1));
  assign almostempty = (count == CNT_W'(1));

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // Rejection pulses are suppressed when the opposite request makes progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_ok;
      overflow  <= wr_en && full && !rd_en;
      underflow <= rd_en && empty && !wr_en;
    end
  end

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed steps followed by random traffic,
// compared against a queue-based reference model.
module tb_fifo;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] data_out;
  logic         wr_ack, overflow, underflow, full, empty, almostfull, almostempty;

  fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = '0;
  logic         m_ack = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour at one rising edge, in terms of queue occupancy.
  task automatic model_edge(input logic rn, input logic wr, input logic rd, input logic [W-1:0] din);
    bit was_full, was_empty;
    if (!rn) begin
      q.delete();
      m_dout = '0; m_ack = 0; m_ovf = 0; m_udf = 0;
      return;
    end
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    m_ack = wr && !was_full;
    m_ovf = wr && was_full && !rd;
    m_udf = rd && was_empty && !wr;
    if (rd && !was_empty) m_dout = q.pop_front();
    if (wr && !was_full) q.push_back(din);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"},    32'(data_out),    32'(m_dout));
    chk({tag, ".wr_ack"},      32'(wr_ack),      32'(m_ack));
    chk({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
    chk({tag, ".underflow"},   32'(underflow),   32'(m_udf));
    chk({tag, ".full"},        32'(full),        32'(q.size() == D));
    chk({tag, ".empty"},       32'(empty),       32'(q.size() == 0));
    chk({tag, ".almostfull"},  32'(almostfull),  32'(q.size() == D - 1));
    chk({tag, ".almostempty"}, 32'(almostempty), 32'(q.size() == 1));
  endtask

  // Drive one cycle of requests, advance past the edge and compare.
  task automatic step(input string tag, input logic rn, input logic wr, input logic rd,
                      input logic [W-1:0] din);
    rst_n = rn; wr_en = wr; rd_en = rd; data_in = din;
    @(posedge clk);
    model_edge(rn, wr, rd, din);
    #1;
    check_all(tag);
  endtask

  initial begin
    // reset held for two cycles
    step("rst0", 0, 0, 0, '0);
    step("rst1", 0, 0, 0, '0);
    chk("rst.empty_const", 32'(empty), 32'd1);
    chk("rst.dout_const", 32'(data_out), 32'd0);

    for (int i = 1; i <= D; i++) begin
      step("fill", 1, 1, 0, W'(i));
      chk("fill.ack_const", 32'(wr_ack), 32'd1);
    end
    chk("fill.full_const", 32'(full), 32'd1);

    step("ovf", 1, 1, 0, 16'hDEAD);
    chk("ovf.const", 32'(overflow), 32'd1);

    for (int i = 1; i <= D; i++) begin
      step("drain", 1, 0, 1, '0);
      chk("drain.order_const", 32'(data_out), 32'(i));
    end
    step("udf", 1, 0, 1, '0);
    chk("udf.const", 32'(underflow), 32'd1);
    chk("udf.hold_const", 32'(data_out), 32'h0008);

    // simultaneous read/write at count 3
    for (int i = 0; i < 3; i++) step("pre3", 1, 1, 0, W'(16'h0100 + i));
    step("sim3", 1, 1, 1, 16'h0200);
    chk("sim3.oldest_const", 32'(data_out), 32'h0100);
    chk("sim3.count", 32'(q.size()), 32'd3);
    for (int i = 0; i < 3; i++) step("post3", 1, 0, 1, '0);

    // simultaneous at empty: write only
    step("sim0", 1, 1, 1, 16'h0300);
    chk("sim0.noudf_const", 32'(underflow), 32'd0);
    chk("sim0.ae_const", 32'(almostempty), 32'd1);

    // simultaneous at full: read only
    for (int i = 1; i < D; i++) step("pre8", 1, 1, 0, W'(16'h0300 + i));
    step("sim8", 1, 1, 1, 16'hBEEF);
    chk("sim8.noovf_const", 32'(overflow), 32'd0);
    chk("sim8.af_const", 32'(almostfull), 32'd1);

    // reset in mid-operation with count 5
    for (int i = 0; i < 2; i++) step("down5", 1, 0, 1, '0);
    step("rstmid", 0, 0, 0, '0);
    chk("rstmid.empty_const", 32'(empty), 32'd1);
    step("rstrd", 1, 0, 1, '0);
    chk("rstrd.udf_const", 32'(underflow), 32'd1);

    // pointer wrap with steady occupancy
    step("wrap_pre", 1, 1, 0, 16'h0A00);
    step("wrap_pre", 1, 1, 0, 16'h0A01);
    for (int i = 0; i < 20; i++) step("wrap", 1, 1, 1, W'(16'h0B00 + i));

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      logic rn;
      rn = ($urandom_range(0, 63) != 0);
      step("rand", rn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
